pipe_ctrl: RTL and testbench

- Central sequencer for the five-stage datapath.
- Drives the enable/flush pair of every pipeline register (if_id, id_ex, ex_mem, mem_wb) and the PC enable.
- Arbitrates imem/dmem wait states, load-use bubbles, control-flow redirects and halt draining.
- Sits beside the datapath; its only state is a halt FSM, two memory-completion latches and a stall counter.

---
 rtl/dp_types_pkg.sv | 38 +++
 rtl/hazard_unit.sv | 17 +
 rtl/pipe_ctrl.sv | 126 ++++++++++++
 tb/tb_pipe_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_types_pkg.sv
// Shared types for the pipeline sequencer.
// Halt FSM states and the per-cycle register control bundle.
package dp_types_pkg;

  localparam int STALL_W_DEF = 16;
  localparam int REG_W_DEF   = 5;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } pipe_state_t;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic exmem_flush;
    logic memwb_en;
    logic memwb_flush;
  } pipe_ctrl_t;

  // Every register enabled, no flushes: the plain advance pattern.
  function automatic pipe_ctrl_t ctrl_advance();
    pipe_ctrl_t c;
    c = '0;
    c.pc_en    = 1'b1;
    c.ifid_en  = 1'b1;
    c.idex_en  = 1'b1;
    c.exmem_en = 1'b1;
    c.memwb_en = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/hazard_unit.sv
// Load-use compare between the id_ex load and the if_id sources.
// Register 0 never creates a dependency.
module hazard_unit #(
  parameter int REG_W = dp_types_pkg::REG_W_DEF
) (
  input  logic             idex_memread,
  input  logic [REG_W-1:0] idex_rd,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  output logic             lu_hazard
);

  assign lu_hazard = idex_memread
                   & (idex_rd != '0)
                   & ((idex_rd == ifid_rs) | (idex_rd == ifid_rt));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: register enables/flushes, PC enable,
// memory wait arbitration, load-use bubbles and halt draining.
module pipe_ctrl
  import dp_types_pkg::*;
#(
  parameter int STALL_W = STALL_W_DEF,
  parameter int REG_W   = REG_W_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               ihit,
  input  logic               dhit,
  input  logic               exmem_dren,
  input  logic               exmem_dwen,
  input  logic               idex_memread,
  input  logic [REG_W-1:0]   idex_rd,
  input  logic [REG_W-1:0]   ifid_rs,
  input  logic [REG_W-1:0]   ifid_rt,
  input  logic               ifid_halt,
  input  logic               ex_redirect,
  input  logic               wb_halt,
  output logic               pc_en,
  output logic               ifid_en,
  output logic               ifid_flush,
  output logic               idex_en,
  output logic               idex_flush,
  output logic               exmem_en,
  output logic               exmem_flush,
  output logic               memwb_en,
  output logic               memwb_flush,
  output logic               halt,
  output logic [STALL_W-1:0] stall_cnt
);

  pipe_state_t        state_q;
  logic               imem_done_q;
  logic               dmem_done_q;
  logic [STALL_W-1:0] cnt_q;

  logic       lu_hazard;
  logic       dmem_req;
  logic       dmem_ok;
  logic       imem_ok;
  logic       advance;
  logic       bubble;
  logic       stall_ev;
  pipe_ctrl_t ctl;

  hazard_unit #(
    .REG_W(REG_W)
  ) u_hazard (
    .idex_memread(idex_memread),
    .idex_rd     (idex_rd),
    .ifid_rs     (ifid_rs),
    .ifid_rt     (ifid_rt),
    .lu_hazard   (lu_hazard)
  );

  assign dmem_req = exmem_dren | exmem_dwen;
  assign dmem_ok  = ~dmem_req | dhit | dmem_done_q;
  assign imem_ok  = ihit | imem_done_q;
  assign advance  = imem_ok & dmem_ok;
  assign bubble   = advance & lu_hazard & ~ex_redirect;
  assign stall_ev = ~advance | bubble;

  // Register controls; a redirect outranks a load-use bubble.
  always_comb begin
    ctl = '0;
    if (!RST && advance && state_q != HALTED) begin
      ctl = ctrl_advance();
      if (ex_redirect) begin
        ctl.ifid_flush = 1'b1;
        ctl.idex_flush = 1'b1;
      end else if (state_q == DRAIN) begin
        ctl.pc_en      = 1'b0;
        ctl.ifid_flush = 1'b1;
        ctl.idex_flush = lu_hazard;
      end else if (lu_hazard) begin
        ctl.pc_en      = 1'b0;
        ctl.ifid_en    = 1'b0;
        ctl.idex_flush = 1'b1;
      end
    end
  end

  assign pc_en       = ctl.pc_en;
  assign ifid_en     = ctl.ifid_en;
  assign ifid_flush  = ctl.ifid_flush;
  assign idex_en     = ctl.idex_en;
  assign idex_flush  = ctl.idex_flush;
  assign exmem_en    = ctl.exmem_en;
  assign exmem_flush = ctl.exmem_flush;
  assign memwb_en    = ctl.memwb_en;
  assign memwb_flush = ctl.memwb_flush;
  assign halt        = ~RST & (state_q == HALTED);
  assign stall_cnt   = RST ? '0 : cnt_q;

  // Halt FSM, memory-completion latches and saturating stall count.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= RUN;
      imem_done_q <= 1'b0;
      dmem_done_q <= 1'b0;
      cnt_q       <= '0;
    end else if (state_q != HALTED) begin
      if (stall_ev && cnt_q != '1)
        cnt_q <= cnt_q + STALL_W'(1);
      imem_done_q <= ~advance & (imem_done_q | ihit);
      dmem_done_q <= ~advance & (dmem_done_q | dhit);
      if (wb_halt) begin
        state_q <= HALTED;
      end else begin
        unique case (state_q)
          RUN:
            if (advance && ifid_halt && !ex_redirect && !lu_hazard)
              state_q <= DRAIN;
          DRAIN:
            if (advance && ex_redirect)
              state_q <= RUN;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl.
// Two instances: default counter width and a 3-bit counter.
module tb_pipe_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       ihit = 1'b0, dhit = 1'b0;
  logic       exmem_dren = 1'b0, exmem_dwen = 1'b0;
  logic       idex_memread = 1'b0;
  logic [4:0] idex_rd = '0, ifid_rs = '0, ifid_rt = '0;
  logic       ifid_halt = 1'b0, ex_redirect = 1'b0, wb_halt = 1'b0;

  logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic        exmem_en, exmem_flush, memwb_en, memwb_flush, halt;
  logic [15:0] stall_cnt;
  logic        pc_en3, ifid_en3, ifid_flush3, idex_en3, idex_flush3;
  logic        exmem_en3, exmem_flush3, memwb_en3, memwb_flush3, halt3;
  logic [2:0]  stall_cnt3;

  always #5 CLK = ~CLK;

  pipe_ctrl dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .exmem_dren(exmem_dren), .exmem_dwen(exmem_dwen),
    .idex_memread(idex_memread), .idex_rd(idex_rd),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_halt(ifid_halt), .ex_redirect(ex_redirect),
    .wb_halt(wb_halt), .pc_en(pc_en),
    .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush),
    .exmem_en(exmem_en), .exmem_flush(exmem_flush),
    .memwb_en(memwb_en), .memwb_flush(memwb_flush),
    .halt(halt), .stall_cnt(stall_cnt)
  );

  pipe_ctrl #(.STALL_W(3)) dut3 (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .exmem_dren(exmem_dren), .exmem_dwen(exmem_dwen),
    .idex_memread(idex_memread), .idex_rd(idex_rd),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_halt(ifid_halt), .ex_redirect(ex_redirect),
    .wb_halt(wb_halt), .pc_en(pc_en3),
    .ifid_en(ifid_en3), .ifid_flush(ifid_flush3),
    .idex_en(idex_en3), .idex_flush(idex_flush3),
    .exmem_en(exmem_en3), .exmem_flush(exmem_flush3),
    .memwb_en(memwb_en3), .memwb_flush(memwb_flush3),
    .halt(halt3), .stall_cnt(stall_cnt3)
  );

  typedef struct {
    logic [9:0]  ctl;
    logic [15:0] c16;
    logic [2:0]  c3;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  bit m_halted = 0, m_drain = 0, m_idone = 0, m_ddone = 0;
  int m_stalls = 0;

  function automatic bit lu_now();
    return idex_memread && idex_rd != 0 &&
           (idex_rd == ifid_rs || idex_rd == ifid_rt);
  endfunction

  function automatic bit go_now();
    bit need_d;
    need_d = exmem_dren || exmem_dwen;
    return (ihit || m_idone) && (!need_d || dhit || m_ddone);
  endfunction

  function automatic exp_t predict();
    exp_t e;
    bit pc, fe, ff, de, df, xe, we;
    e.ctl = '0; e.c16 = '0; e.c3 = '0;
    if (RST) return e;
    e.c16 = (m_stalls > 65535) ? 16'hFFFF : 16'(m_stalls);
    e.c3  = (m_stalls > 7) ? 3'd7 : 3'(m_stalls);
    if (m_halted) begin
      e.ctl = 10'b00_0000_0001;
      return e;
    end
    {pc, fe, ff, de, df, xe, we} = '0;
    if (go_now()) begin
      {pc, fe, de, xe, we} = 5'b11111;
      if (ex_redirect) begin
        ff = 1; df = 1;
      end else if (m_drain) begin
        pc = 0; ff = 1; df = lu_now();
      end else if (lu_now()) begin
        pc = 0; fe = 0; df = 1;
      end
    end
    e.ctl = {pc, fe, ff, de, df, xe, 1'b0, we, 1'b0, 1'b0};
    return e;
  endfunction

  function automatic void update_model();
    bit go, lu;
    if (RST) begin
      m_halted = 0; m_drain = 0; m_idone = 0; m_ddone = 0;
      m_stalls = 0;
      return;
    end
    if (m_halted) return;
    go = go_now();
    lu = lu_now();
    if (!go || (lu && !ex_redirect)) m_stalls++;
    if (wb_halt) begin
      m_halted = 1; m_drain = 0;
    end else if (!m_drain && go && ifid_halt && !ex_redirect && !lu) begin
      m_drain = 1;
    end else if (m_drain && go && ex_redirect) begin
      m_drain = 0;
    end
    if (go) begin
      m_idone = 0; m_ddone = 0;
    end else begin
      m_idone = m_idone | ihit;
      m_ddone = m_ddone | dhit;
    end
  endfunction

  task automatic cyc();
    sbq.push_back(predict());
    @(posedge CLK);
    update_model();
    #1;
  endtask

  task automatic clr();
    ihit = 0; dhit = 0; exmem_dren = 0; exmem_dwen = 0;
    idex_memread = 0; idex_rd = 0; ifid_rs = 0; ifid_rt = 0;
    ifid_halt = 0; ex_redirect = 0; wb_halt = 0;
  endtask

  task automatic do_reset();
    RST = 1; cyc(); cyc(); RST = 0;
  endtask

  // Monitor: pop one expectation per cycle, compare both instances.
  always @(negedge CLK) begin
    exp_t e;
    logic [9:0] a, a3;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      a  = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
            exmem_en, exmem_flush, memwb_en, memwb_flush, halt};
      a3 = {pc_en3, ifid_en3, ifid_flush3, idex_en3, idex_flush3,
            exmem_en3, exmem_flush3, memwb_en3, memwb_flush3, halt3};
      checks += 4;
      if (a !== e.ctl) begin
        errors++;
        $display("FAIL ctl t=%0t got %b want %b", $time, a, e.ctl);
      end
      if (a3 !== e.ctl) begin
        errors++;
        $display("FAIL ctl3 t=%0t got %b want %b", $time, a3, e.ctl);
      end
      if (stall_cnt !== e.c16) begin
        errors++;
        $display("FAIL cnt16 t=%0t got %0d want %0d",
                 $time, stall_cnt, e.c16);
      end
      if (stall_cnt3 !== e.c3) begin
        errors++;
        $display("FAIL cnt3 t=%0t got %0d want %0d",
                 $time, stall_cnt3, e.c3);
      end
    end
  end

  initial begin
    @(posedge CLK); #1;
    // Reset with ihit high, then free-running advance.
    clr(); ihit = 1; do_reset();
    cyc(); cyc();
    // Port conflict between imem and dmem.
    do_reset();
    exmem_dren = 1; ihit = 1; dhit = 0;
    repeat (3) cyc();
    ihit = 0; dhit = 1; cyc();
    ihit = 1; dhit = 0; cyc();
    exmem_dren = 0; cyc();
    // Load-use, then rd=0 which is never a hazard.
    idex_memread = 1; idex_rd = 8; ifid_rs = 8; cyc();
    idex_rd = 0; ifid_rs = 0; cyc();
    // Redirect beats load-use.
    idex_rd = 8; ifid_rs = 8; ex_redirect = 1; cyc();
    clr(); ihit = 1;
    // Halt enters drain, cancelled by redirect.
    ifid_halt = 1; cyc();
    ifid_halt = 0; cyc(); cyc();
    ex_redirect = 1; cyc();
    ex_redirect = 0; cyc();
    // Halt again, then write-back of the halt.
    ifid_halt = 1; cyc();
    ifid_halt = 0; cyc();
    wb_halt = 1; cyc();
    wb_halt = 0;
    for (int i = 0; i < 10; i++) begin
      ihit = 1'($urandom); dhit = 1'($urandom); cyc();
    end
    // Saturation of the narrow counter.
    clr(); do_reset();
    repeat (10) cyc();
    // Reset in the middle of a stall clears the latches.
    exmem_dren = 1; ihit = 1; cyc();
    RST = 1; cyc(); RST = 0;
    ihit = 0; dhit = 1; cyc();
    ihit = 1; cyc();
    // Randomized traffic.
    clr(); do_reset();
    for (int i = 0; i < 3000; i++) begin
      RST          = ($urandom_range(0, 99) < 2);
      ihit         = ($urandom_range(0, 99) < 75);
      dhit         = ($urandom_range(0, 99) < 60);
      exmem_dren   = ($urandom_range(0, 99) < 25);
      exmem_dwen   = ($urandom_range(0, 99) < 15);
      idex_memread = ($urandom_range(0, 99) < 30);
      idex_rd      = 5'($urandom_range(0, 3));
      ifid_rs      = 5'($urandom_range(0, 3));
      ifid_rt      = 5'($urandom_range(0, 3));
      ifid_halt    = ($urandom_range(0, 99) < 10);
      ex_redirect  = ($urandom_range(0, 99) < 15);
      wb_halt      = ($urandom_range(0, 99) < 1);
      cyc();
    end
    RST = 0; clr();
    repeat (2) @(negedge CLK);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
